// File: rtl/cam_if_pkg.sv
`default_nettype none
// ============================================================================
// cam_if_pkg : shared state/pattern types and RGB565 bar colours for the
//              OV7670 stream emulator.
// Revision   : 1.0
// ============================================================================
package cam_if_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VSYNC   = 3'd1,
    V_BACK  = 3'd2,
    ACTIVE  = 3'd3,
    V_FRONT = 3'd4
  } emu_state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ============================================================================
// cam_pattern_gen : combinational test-pattern source, (x, y) -> RGB565.
// Revision        : 1.0
// ============================================================================
module cam_pattern_gen
  import cam_if_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  pattern_t       pattern,
  input  logic [15:0]    solid,
  output logic [15:0]    rgb
);

  logic [2:0] bar;
  logic       in_box;

  always_comb begin
    bar    = 3'(int'(x) / (H_ACTIVE / 8));
    in_box = (int'(x) >= H_ACTIVE / 4) && (int'(x) < 3 * H_ACTIVE / 4) &&
             (int'(y) >= V_ACTIVE / 4) && (int'(y) < 3 * V_ACTIVE / 4);
    rgb    = 16'h0000;
    case (pattern)
      PAT_BARS: begin
        case (bar)
          3'd0:    rgb = RGB_WHITE;
          3'd1:    rgb = RGB_YELLOW;
          3'd2:    rgb = RGB_CYAN;
          3'd3:    rgb = RGB_GREEN;
          3'd4:    rgb = RGB_MAGENTA;
          3'd5:    rgb = RGB_RED;
          3'd6:    rgb = RGB_BLUE;
          default: rgb = RGB_BLACK;
        endcase
      end
      PAT_SOLID: rgb = solid;
      // Size casts zero-extend narrow coordinates and truncate wide ones.
      PAT_GRAD:  rgb = {5'(x), 6'(y), 5'(x) ^ 5'(y)};
      PAT_BOX:   rgb = in_box ? solid : 16'h0000;
      default:   rgb = 16'h0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_emulator.sv
`default_nettype none
// ============================================================================
// ov7670_stream_emulator : OV7670-style pclk/vsync/href/data transmitter
//                          producing RGB565 test frames, high byte first.
// Revision               : 1.0
// ============================================================================
module ov7670_stream_emulator
  import cam_if_pkg::*;
#(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int L        = 2 * H_ACTIVE + H_BLANK;
  localparam int SLOT_W   = $clog2(L);
  localparam int LINE_MAX = (V_ACTIVE > VSYNC_LINES && V_ACTIVE > V_BACK && V_ACTIVE > V_FRONT)
                            ? V_ACTIVE
                            : ((VSYNC_LINES > V_BACK && VSYNC_LINES > V_FRONT) ? VSYNC_LINES
                               : ((V_BACK > V_FRONT) ? V_BACK : V_FRONT));
  localparam int LINE_W   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int X_W      = $clog2(H_ACTIVE);
  localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [2:0] ST_IDLE    = cam_if_pkg::IDLE;
  localparam logic [2:0] ST_VSYNC   = cam_if_pkg::VSYNC;
  localparam logic [2:0] ST_V_BACK  = cam_if_pkg::V_BACK;
  localparam logic [2:0] ST_ACTIVE  = cam_if_pkg::ACTIVE;
  localparam logic [2:0] ST_V_FRONT = cam_if_pkg::V_FRONT;

  logic              pclk_q, pclk_d;
  logic [2:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LINE_W-1:0] line_q, line_d, last_line;
  pattern_t          pat_q, pat_d;
  logic [15:0]       solid_q, solid_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              last_slot, at_last_line, frame_end, start;
  logic [X_W-1:0]    x_d;
  logic [Y_W-1:0]    y_d;
  logic [15:0]       pix;

  // Slot position advances on the clk edge where pclk falls (pclk_q == 1).
  always_comb begin
    case (state_q)
      ST_VSYNC:   last_line = LINE_W'(VSYNC_LINES - 1);
      ST_V_BACK:  last_line = LINE_W'(V_BACK - 1);
      ST_ACTIVE:  last_line = LINE_W'(V_ACTIVE - 1);
      ST_V_FRONT: last_line = LINE_W'(V_FRONT - 1);
      default:    last_line = '0;
    endcase
    last_slot    = (slot_q == SLOT_W'(L - 1));
    at_last_line = (line_q == last_line);
    frame_end    = (state_q == ST_V_FRONT) && at_last_line && last_slot;
    start        = 1'b0;
    state_d      = state_q;
    slot_d       = slot_q;
    line_d       = line_q;
    if (pclk_q) begin
      if (state_q == ST_IDLE) begin
        start = enable;
      end else if (last_slot) begin
        slot_d = '0;
        if (at_last_line) begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:   state_d = ST_V_BACK;
            ST_V_BACK:  state_d = ST_ACTIVE;
            ST_ACTIVE:  state_d = ST_V_FRONT;
            ST_V_FRONT: begin
              state_d = ST_IDLE;
              start   = enable;
            end
            default:    state_d = ST_IDLE;
          endcase
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
      if (start) begin
        state_d = ST_VSYNC;
        slot_d  = '0;
        line_d  = '0;
      end
    end
    pat_d   = start ? pattern_t'(pattern_sel) : pat_q;
    solid_d = start ? solid_rgb565 : solid_q;
  end

  assign pclk_d = ~pclk_q;
  assign x_d    = X_W'(slot_d >> 1);
  assign y_d    = Y_W'(line_d);

  // The pixel for the upcoming slot is looked up now and registered with it.
  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_pattern_gen (
    .x       (x_d),
    .y       (y_d),
    .pattern (pat_q),
    .solid   (solid_q),
    .rgb     (pix)
  );

  always_comb begin
    // frame_done occupies the second clk of the frame's final slot.
    frame_done_d = !pclk_q && frame_end;
    frame_cnt_d  = frame_cnt_q + (frame_done_d ? 8'd1 : 8'd0);
    vsync_d      = vsync_q;
    href_d       = href_q;
    data_d       = data_q;
    if (pclk_q) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (slot_d < SLOT_W'(2 * H_ACTIVE));
      data_d  = href_d ? (slot_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_q       <= 1'b0;
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      line_q       <= '0;
      pat_q        <= PAT_BARS;
      solid_q      <= 16'h0000;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      pclk_q       <= pclk_d;
      state_q      <= state_d;
      slot_q       <= slot_d;
      line_q       <= line_d;
      pat_q        <= pat_d;
      solid_q      <= solid_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign cam_pclk   = pclk_q;
  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_emulator.sv
`default_nettype none
// ============================================================================
// tb_ov7670_stream_emulator : directed, table-driven bench for the emulator
//                             on an 8x4 frame (L = 20 slots, 7 lines).
// Revision                  : 1.0
// ============================================================================
module tb_ov7670_stream_emulator;

  localparam int H_ACTIVE = 8, V_ACTIVE = 4, H_BLANK = 4;
  localparam int VSYNC_LINES = 1, V_BACK = 1, V_FRONT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb565 = 16'h0000;
  logic        cam_pclk, cam_vsync, cam_href, frame_done;
  logic [7:0]  cam_data, frame_cnt;

  always #5 clk = ~clk;

  ov7670_stream_emulator #(
    .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES), .V_BACK (V_BACK), .V_FRONT (V_FRONT)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .pattern_sel (pattern_sel),
    .solid_rgb565 (solid_rgb565), .cam_pclk (cam_pclk), .cam_vsync (cam_vsync),
    .cam_href (cam_href), .cam_data (cam_data), .frame_done (frame_done),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [1:0]  pat;
    int          line;
    int          px;
    logic [15:0] rgb;
  } vec_t;

  vec_t        vecs [18];
  logic [15:0] bars_exp [8];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_cnt = 8'd0;

  // Slot-level monitor: one sample per slot, taken while pclk is high.
  logic [7:0] cap [4][16];
  int vs_len = 0, gap = 0, href_lines = 0, hi_len = 0, lo_len = 0, byte_i = 0;
  int bad_data = 0, done_clks = 0;
  int hi_lens [4];
  int lo_lens [4];
  bit prev_vs = 0, prev_href = 0, in_gap = 0;

  always @(negedge clk) begin
    if (frame_done) done_clks++;
    if (!reset) begin
      prev_vs = 0; prev_href = 0; in_gap = 0;
    end else if (cam_pclk) begin
      if (cam_vsync && !prev_vs) begin
        vs_len = 0; gap = 0; href_lines = 0; bad_data = 0;
      end
      if (!cam_vsync && prev_vs) in_gap = 1;
      if (cam_vsync) vs_len++;
      if (cam_href) begin
        if (!prev_href) begin
          hi_len = 0; byte_i = 0; in_gap = 0;
          if (href_lines > 0 && href_lines < 4) lo_lens[href_lines] = lo_len;
        end
        if (href_lines < 4 && byte_i < 16) cap[href_lines][byte_i] = cam_data;
        byte_i++; hi_len++;
      end else begin
        if (prev_href) begin
          if (href_lines < 4) hi_lens[href_lines] = hi_len;
          href_lines++; lo_len = 0;
        end
        lo_len++;
        if (in_gap) gap++;
        if (cam_data != 8'h00) bad_data++;
      end
      prev_vs = cam_vsync; prev_href = cam_href;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix_at(input int line, input int px);
    return {cap[line][2*px], cap[line][2*px+1]};
  endfunction

  task automatic wait_done(input int max_clk, output bit ok);
    int start;
    start = done_clks;
    ok = 0;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (done_clks != start) begin ok = 1; break; end
    end
  endtask

  // Starts one frame, drops enable once it is under way, waits for its end.
  task automatic run_frame(input logic [1:0] p, input logic [15:0] s, output bit ok);
    bit seen;
    seen = 0;
    @(negedge clk);
    pattern_sel = p; solid_rgb565 = s; enable = 1'b1; done_clks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cam_vsync) begin seen = 1; break; end
    end
    enable = 1'b0;
    ok = 0;
    if (seen) wait_done(400, ok);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic apply_vecs(input logic [1:0] p);
    for (int i = 0; i < 18; i++)
      if (vecs[i].pat == p)
        chk($sformatf("pat%0d y%0d x%0d", p, vecs[i].line, vecs[i].px),
            pix_at(vecs[i].line, vecs[i].px), vecs[i].rgb);
  endtask

  task automatic check_timing(input string tag);
    chk({tag, " vsync slots"}, vs_len, 20);
    chk({tag, " vsync-to-href slots"}, gap, 20);
    chk({tag, " href pulses"}, href_lines, 4);
    chk({tag, " frame_done clks"}, done_clks, 1);
    chk({tag, " frame_cnt"}, frame_cnt, exp_cnt);
  endtask

  initial begin
    bit ok;
    int need, idle_vs, idle_href;
    bars_exp = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    vecs[0]  = '{2'd0, 0, 0, 16'hFFFF};
    vecs[1]  = '{2'd0, 0, 1, 16'hFFE0};
    vecs[2]  = '{2'd0, 0, 2, 16'h07FF};
    vecs[3]  = '{2'd0, 0, 3, 16'h07E0};
    vecs[4]  = '{2'd0, 0, 4, 16'hF81F};
    vecs[5]  = '{2'd0, 0, 5, 16'hF800};
    vecs[6]  = '{2'd0, 0, 6, 16'h001F};
    vecs[7]  = '{2'd0, 0, 7, 16'h0000};
    vecs[8]  = '{2'd2, 2, 3, 16'h1841};
    vecs[9]  = '{2'd2, 1, 7, 16'h3826};
    vecs[10] = '{2'd2, 3, 0, 16'h0063};
    vecs[11] = '{2'd2, 0, 5, 16'h2805};
    vecs[12] = '{2'd3, 1, 2, 16'hF800};
    vecs[13] = '{2'd3, 2, 5, 16'hF800};
    vecs[14] = '{2'd3, 1, 1, 16'h0000};
    vecs[15] = '{2'd3, 0, 3, 16'h0000};
    vecs[16] = '{2'd3, 3, 4, 16'h0000};
    vecs[17] = '{2'd3, 2, 6, 16'h0000};

    // Reset held, then idle with enable low.
    repeat (3) @(negedge clk);
    chk("reset pclk", cam_pclk, 0);
    chk("reset vsync/href/data/done", {cam_vsync, cam_href, cam_data, frame_done}, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle pclk toggle", cam_pclk, (i % 2 == 0) ? 1 : 0);
      chk("idle outputs", {cam_vsync, cam_href, cam_data, frame_done}, 0);
    end
    chk("idle frame_cnt", frame_cnt, 0);

    // Colour bars frame with full timing checks.
    run_frame(2'd0, 16'h0000, ok);
    chk("bars frame completes", ok, 1);
    check_timing("bars");
    for (int l = 0; l < 4; l++) chk($sformatf("href high slots line%0d", l), hi_lens[l], 16);
    for (int l = 1; l < 4; l++) chk($sformatf("href low slots before line%0d", l), lo_lens[l], 4);
    chk("bars data zero when href low", bad_data, 0);
    apply_vecs(2'd0);
    for (int l = 1; l < 4; l++)
      for (int x = 0; x < 8; x++)
        chk($sformatf("bars y%0d x%0d", l, x), pix_at(l, x), bars_exp[x]);

    // Centre box.
    run_frame(2'd3, 16'hF800, ok);
    chk("box frame completes", ok, 1);
    chk("box frame_cnt", frame_cnt, exp_cnt);
    apply_vecs(2'd3);
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < 8; x++)
        chk($sformatf("box y%0d x%0d", l, x), pix_at(l, x),
            (l >= 1 && l <= 2 && x >= 2 && x <= 5) ? 16'hF800 : 16'h0000);

    // Gradient.
    run_frame(2'd2, 16'h0000, ok);
    chk("grad frame completes", ok, 1);
    chk("grad frame_cnt", frame_cnt, exp_cnt);
    apply_vecs(2'd2);

    // Enable drop and pattern change during active line 2.
    @(negedge clk);
    pattern_sel = 2'd0; solid_rgb565 = 16'h0000; enable = 1'b1; done_clks = 0;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (href_lines == 2 && cam_href) begin ok = 1; break; end
    end
    chk("reached active line 2", ok, 1);
    enable = 1'b0; pattern_sel = 2'd1; solid_rgb565 = 16'h1234;
    wait_done(400, ok);
    exp_cnt = exp_cnt + 8'd1;
    chk("mid-frame frame completes", ok, 1);
    check_timing("mid-frame");
    for (int l = 2; l < 4; l++)
      for (int x = 0; x < 8; x++)
        chk($sformatf("mid-frame bars y%0d x%0d", l, x), pix_at(l, x), bars_exp[x]);
    idle_vs = 0; idle_href = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cam_vsync) idle_vs++;
      if (cam_href) idle_href++;
    end
    chk("post-frame idle vsync clks", idle_vs, 0);
    chk("post-frame idle href clks", idle_href, 0);
    chk("post-frame single frame_done", done_clks, 1);

    // Run frames back to back until frame_cnt wraps.
    need = 256 - int'(exp_cnt);
    @(negedge clk);
    pattern_sel = 2'd0; enable = 1'b1;
    for (int i = 0; i < need; i++) begin
      wait_done(400, ok);
      if (!ok) begin chk("wrap frame completes", ok, 1); break; end
      exp_cnt = exp_cnt + 8'd1;
      if (i == need - 2) chk("frame_cnt before wrap", frame_cnt, 8'd255);
    end
    chk("frame_cnt wrapped", frame_cnt, 0);

    // Asynchronous reset in the middle of an href pulse.
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cam_href) begin ok = 1; break; end
    end
    chk("href seen before async reset", ok, 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset pclk", cam_pclk, 0);
    chk("async reset vsync", cam_vsync, 0);
    chk("async reset href", cam_href, 0);
    chk("async reset data", cam_data, 0);
    chk("async reset frame_done", frame_done, 0);
    chk("async reset frame_cnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1; enable = 1'b1; done_clks = 0; exp_cnt = 8'd1;
    wait_done(400, ok);
    chk("post-reset frame completes", ok, 1);
    check_timing("post-reset");
    enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
